// File: rtl/lfsr_prbs_pkg.sv
// Shared definitions for the PRBS error monitor: sync-state encoding and
// the width of a per-word error popcount.
package lfsr_prbs_pkg;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } mon_state_e;

    function automatic int pcnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/lfsr_prbs_popcount.sv
// Registered popcount stage: counts error bits in each checker word and
// carries the word-valid flag alongside.
module lfsr_prbs_popcount
    import lfsr_prbs_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PW         = pcnt_width(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] err_i,
    input  logic                  valid_i,
    output logic [PW-1:0]         count_o,
    output logic                  valid_o
);

    logic [PW-1:0] count_d;
    logic [PW-1:0] count_q;
    logic          valid_q;

    always_comb begin
        count_d = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            count_d = count_d + PW'(err_i[i]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            valid_q <= valid_i;
        end
    end

    assign count_o = count_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/lfsr_prbs_err_mon.sv
// PRBS error monitor: HUNT/LOCKED sync tracking on popcounted checker words,
// saturating totals while locked, and per-window error counts for BER.
module lfsr_prbs_err_mon
    import lfsr_prbs_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int COUNT_WIDTH  = 32,
    parameter int WINDOW_WIDTH = 16,
    parameter int LOCK_COUNT   = 64,
    parameter int UNLOCK_COUNT = 4,
    parameter int BAD_BITS     = DATA_WIDTH / 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [DATA_WIDTH-1:0]   err_in_i,
    input  logic                    err_in_valid_i,
    input  logic                    clear_i,
    input  logic [WINDOW_WIDTH-1:0] window_len_i,
    output logic                    locked_o,
    output logic                    lock_lost_o,
    output logic [COUNT_WIDTH-1:0]  err_count_o,
    output logic [COUNT_WIDTH-1:0]  bit_count_o,
    output logic [COUNT_WIDTH-1:0]  win_err_count_o,
    output logic                    win_valid_o
);

    localparam int PW  = pcnt_width(DATA_WIDTH);
    localparam int CW  = COUNT_WIDTH;
    localparam int WW  = WINDOW_WIDTH;
    localparam int CRW = $clog2(LOCK_COUNT + 1);
    localparam int BRW = $clog2(UNLOCK_COUNT + 1);

    localparam logic [PW:0]    BAD_THR  = (PW + 1)'(BAD_BITS);
    localparam logic [CRW-1:0] LOCK_THR = CRW'(LOCK_COUNT);
    localparam logic [BRW-1:0] UNLK_THR = BRW'(UNLOCK_COUNT);

    logic [PW-1:0] pc_q;
    logic          pv_q;

    lfsr_prbs_popcount #(
        .DATA_WIDTH (DATA_WIDTH),
        .PW         (PW)
    ) u_popcount (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .err_i   (err_in_i),
        .valid_i (err_in_valid_i),
        .count_o (pc_q),
        .valid_o (pv_q)
    );

    mon_state_e     state_q, state_d;
    logic [CRW-1:0] clean_run_q, clean_run_d;
    logic [BRW-1:0] bad_run_q, bad_run_d;
    logic [CW-1:0]  err_count_q, err_count_d;
    logic [CW-1:0]  bit_count_q, bit_count_d;
    logic [CW-1:0]  win_err_count_q, win_err_count_d;
    logic [CW-1:0]  win_errs_q, win_errs_d;
    logic [WW-1:0]  win_words_q, win_words_d;
    logic           lock_lost_q, lock_lost_d;
    logic           win_valid_q, win_valid_d;

    logic [CRW-1:0] clean_inc;
    logic [BRW-1:0] bad_inc;
    logic [CW:0]    err_sum, bit_sum, win_sum;
    logic [CW-1:0]  err_sat, bit_sat, win_sat;
    logic [WW:0]    words_inc;
    logic           word_bad;
    logic           win_done;

    assign clean_inc = clean_run_q + 1'b1;
    assign bad_inc   = bad_run_q + 1'b1;
    assign word_bad  = {1'b0, pc_q} >= BAD_THR;

    assign err_sum = {1'b0, err_count_q} + (CW + 1)'(pc_q);
    assign bit_sum = {1'b0, bit_count_q} + (CW + 1)'(DATA_WIDTH);
    assign win_sum = {1'b0, win_errs_q} + (CW + 1)'(pc_q);
    assign err_sat = err_sum[CW] ? '1 : err_sum[CW-1:0];
    assign bit_sat = bit_sum[CW] ? '1 : bit_sum[CW-1:0];
    assign win_sat = win_sum[CW] ? '1 : win_sum[CW-1:0];

    // >= rather than == so a window_len shrunk below the current fill closes on the next word
    assign words_inc = {1'b0, win_words_q} + 1'b1;
    assign win_done  = words_inc >= {1'b0, window_len_i};

    always_comb begin
        state_d         = state_q;
        clean_run_d     = clean_run_q;
        bad_run_d       = bad_run_q;
        err_count_d     = err_count_q;
        bit_count_d     = bit_count_q;
        win_err_count_d = win_err_count_q;
        win_errs_d      = win_errs_q;
        win_words_d     = win_words_q;
        lock_lost_d     = 1'b0;
        win_valid_d     = 1'b0;

        if (pv_q) begin
            case (state_q)
                ST_HUNT: begin
                    if (pc_q == '0) begin
                        if (clean_inc == LOCK_THR) begin
                            state_d         = ST_LOCKED;
                            clean_run_d     = '0;
                            bad_run_d       = '0;
                            err_count_d     = '0;
                            bit_count_d     = '0;
                            win_err_count_d = '0;
                            win_errs_d      = '0;
                            win_words_d     = '0;
                        end else begin
                            clean_run_d = clean_inc;
                        end
                    end else begin
                        clean_run_d = '0;
                    end
                end
                ST_LOCKED: begin
                    err_count_d = err_sat;
                    bit_count_d = bit_sat;
                    if (window_len_i == '0) begin
                        win_errs_d  = '0;
                        win_words_d = '0;
                    end else if (win_done) begin
                        win_err_count_d = win_sat;
                        win_valid_d     = 1'b1;
                        win_errs_d      = '0;
                        win_words_d     = '0;
                    end else begin
                        win_errs_d  = win_sat;
                        win_words_d = words_inc[WW-1:0];
                    end
                    if (word_bad) begin
                        if (bad_inc == UNLK_THR) begin
                            state_d     = ST_HUNT;
                            lock_lost_d = 1'b1;
                            clean_run_d = '0;
                            bad_run_d   = '0;
                            win_errs_d  = '0;
                            win_words_d = '0;
                        end else begin
                            bad_run_d = bad_inc;
                        end
                    end else begin
                        bad_run_d = '0;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        // Clear overrides any counting this cycle but leaves sync tracking alone
        if (clear_i) begin
            err_count_d     = '0;
            bit_count_d     = '0;
            win_err_count_d = '0;
            win_errs_d      = '0;
            win_words_d     = '0;
            win_valid_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= ST_HUNT;
            clean_run_q     <= '0;
            bad_run_q       <= '0;
            err_count_q     <= '0;
            bit_count_q     <= '0;
            win_err_count_q <= '0;
            win_errs_q      <= '0;
            win_words_q     <= '0;
            lock_lost_q     <= 1'b0;
            win_valid_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            clean_run_q     <= clean_run_d;
            bad_run_q       <= bad_run_d;
            err_count_q     <= err_count_d;
            bit_count_q     <= bit_count_d;
            win_err_count_q <= win_err_count_d;
            win_errs_q      <= win_errs_d;
            win_words_q     <= win_words_d;
            lock_lost_q     <= lock_lost_d;
            win_valid_q     <= win_valid_d;
        end
    end

    assign locked_o        = (state_q == ST_LOCKED);
    assign lock_lost_o     = lock_lost_q;
    assign err_count_o     = err_count_q;
    assign bit_count_o     = bit_count_q;
    assign win_err_count_o = win_err_count_q;
    assign win_valid_o     = win_valid_q;

endmodule

// File: tb/tb_lfsr_prbs_err_mon.sv
// Directed bench for the PRBS error monitor: a main instance with a short lock
// sequence, plus a narrow-counter instance for the saturation corner.
module tb_lfsr_prbs_err_mon;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  err1, err2;
    logic        vld1, vld2;
    logic        clr1, clr2;
    logic [15:0] wlen1, wlen2;

    logic        locked1, lost1, wv1;
    logic [31:0] ec1, bc1, wec1;
    logic        locked2, lost2, wv2;
    logic [7:0]  ec2, bc2, wec2;

    int n_chk  = 0;
    int n_fail = 0;

    lfsr_prbs_err_mon #(
        .DATA_WIDTH(8), .COUNT_WIDTH(32), .WINDOW_WIDTH(16),
        .LOCK_COUNT(4), .UNLOCK_COUNT(2), .BAD_BITS(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .err_in_i(err1), .err_in_valid_i(vld1),
        .clear_i(clr1), .window_len_i(wlen1), .locked_o(locked1),
        .lock_lost_o(lost1), .err_count_o(ec1), .bit_count_o(bc1),
        .win_err_count_o(wec1), .win_valid_o(wv1)
    );

    lfsr_prbs_err_mon #(
        .DATA_WIDTH(8), .COUNT_WIDTH(8), .WINDOW_WIDTH(16),
        .LOCK_COUNT(4), .UNLOCK_COUNT(2), .BAD_BITS(9)
    ) dut_sat (
        .clk_i(clk), .rst_i(rst), .err_in_i(err2), .err_in_valid_i(vld2),
        .clear_i(clr2), .window_len_i(wlen2), .locked_o(locked2),
        .lock_lost_o(lost2), .err_count_o(ec2), .bit_count_o(bc2),
        .win_err_count_o(wec2), .win_valid_o(wv2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each call spans exactly one rising edge and returns on the falling edge
    task automatic drv(input logic [7:0] w, input logic v);
        err1 = w;
        vld1 = v;
        @(negedge clk);
    endtask

    task automatic drv2(input logic [7:0] w, input logic v);
        err2 = w;
        vld2 = v;
        @(negedge clk);
    endtask

    task automatic chk_main(input string tag, input logic lk, input logic [31:0] ec,
                            input logic [31:0] bc);
        chk({tag, "_locked"}, 64'(locked1), 64'(lk));
        chk({tag, "_err"},    64'(ec1),     64'(ec));
        chk({tag, "_bits"},   64'(bc1),     64'(bc));
    endtask

    initial begin
        rst = 1'b1;
        err1 = '0; vld1 = 1'b0; clr1 = 1'b0; wlen1 = '0;
        err2 = '0; vld2 = 1'b0; clr2 = 1'b0; wlen2 = '0;
        @(negedge clk);
        @(negedge clk);
        chk_main("reset", 1'b0, 32'd0, 32'd0);
        chk("reset_lost", 64'(lost1), 64'd0);
        chk("reset_wv",   64'(wv1),   64'd0);
        chk("reset_wec",  64'(wec1),  64'd0);
        chk("reset_sat_locked", 64'(locked2), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Lock: four clean words, visible two edges after the fourth
        for (int i = 0; i < 4; i++) drv(8'h00, 1'b1);
        chk("lock_latency", 64'(locked1), 64'd0);
        drv(8'h00, 1'b0);
        chk_main("lock", 1'b1, 32'd0, 32'd0);
        chk("lock_lost_quiet", 64'(lost1), 64'd0);

        // Counting: 2 + 0 + 8 errors over 24 bits
        drv(8'h03, 1'b1);
        drv(8'h00, 1'b1);
        drv(8'hFF, 1'b1);
        drv(8'h00, 1'b0);
        chk_main("count", 1'b1, 32'd10, 32'd24);

        // Unlock: clean word resets bad_run, then two bad words drop lock
        drv(8'h00, 1'b1);
        drv(8'h0F, 1'b1);
        drv(8'hF0, 1'b1);
        chk("unlock_first_bad", 64'(locked1), 64'd1);
        drv(8'h00, 1'b0);
        chk("unlock_pulse", 64'(lost1), 64'd1);
        chk_main("unlock", 1'b0, 32'd18, 32'd48);
        drv(8'h00, 1'b0);
        chk("unlock_pulse_end", 64'(lost1), 64'd0);
        chk("unlock_err_hold", 64'(ec1), 64'd18);

        // Hunt interruption: a nonzero word restarts the clean run
        drv(8'h00, 1'b1);
        drv(8'h00, 1'b1);
        drv(8'h00, 1'b1);
        drv(8'h01, 1'b1);
        drv(8'h00, 1'b1);
        drv(8'h00, 1'b1);
        drv(8'h00, 1'b1);
        drv(8'h00, 1'b0);
        drv(8'h00, 1'b0);
        chk("hunt_three_clean", 64'(locked1), 64'd0);
        chk("hunt_err_hold", 64'(ec1), 64'd18);
        drv(8'h00, 1'b1);
        drv(8'h00, 1'b0);
        chk_main("relock", 1'b1, 32'd0, 32'd0);

        // Window of 3 words: 1 + 2 + 0 errors
        wlen1 = 16'd3;
        drv(8'h01, 1'b1);
        drv(8'h03, 1'b1);
        drv(8'h00, 1'b1);
        chk("win_not_yet", 64'(wv1), 64'd0);
        drv(8'h00, 1'b0);
        chk("win1_valid", 64'(wv1), 64'd1);
        chk("win1_count", 64'(wec1), 64'd3);
        chk_main("win1", 1'b1, 32'd3, 32'd24);
        drv(8'h00, 1'b0);
        chk("win1_pulse_end", 64'(wv1), 64'd0);
        chk("win1_held", 64'(wec1), 64'd3);
        for (int i = 0; i < 3; i++) drv(8'h00, 1'b1);
        drv(8'h00, 1'b0);
        chk("win2_valid", 64'(wv1), 64'd1);
        chk("win2_count", 64'(wec1), 64'd0);

        // Clear coincident with a stage-2 word: that word is dropped
        drv(8'h07, 1'b1);
        clr1 = 1'b1;
        drv(8'h00, 1'b0);
        clr1 = 1'b0;
        chk_main("clear", 1'b1, 32'd0, 32'd0);
        chk("clear_wec", 64'(wec1), 64'd0);
        drv(8'h01, 1'b1);
        drv(8'h00, 1'b0);
        chk_main("after_clear", 1'b1, 32'd1, 32'd8);

        // Async reset mid-window
        drv(8'h01, 1'b1);
        rst = 1'b1;
        #1;
        chk_main("rst_mid", 1'b0, 32'd0, 32'd0);
        chk("rst_mid_wv", 64'(wv1), 64'd0);
        chk("rst_mid_lost", 64'(lost1), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        vld1 = 1'b0;
        drv(8'h00, 1'b0);
        drv(8'h00, 1'b0);
        chk_main("rst_after", 1'b0, 32'd0, 32'd0);

        // Saturation on the 8-bit instance; BAD_BITS=9 keeps it locked
        for (int i = 0; i < 4; i++) drv2(8'h00, 1'b1);
        drv2(8'h00, 1'b0);
        chk("sat_lock", 64'(locked2), 64'd1);
        for (int i = 0; i < 31; i++) drv2(8'hFF, 1'b1);
        drv2(8'h00, 1'b0);
        chk("sat_248_err", 64'(ec2), 64'd248);
        chk("sat_248_bits", 64'(bc2), 64'd248);
        drv2(8'hFF, 1'b1);
        drv2(8'h00, 1'b0);
        chk("sat_clip_err", 64'(ec2), 64'd255);
        chk("sat_clip_bits", 64'(bc2), 64'd255);
        drv2(8'hFF, 1'b1);
        drv2(8'h00, 1'b0);
        chk("sat_hold_err", 64'(ec2), 64'd255);
        chk("sat_hold_locked", 64'(locked2), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
